demod_window_sequencer: RTL and testbench
=========================================

Name: demod_window_sequencer

Overview:
- Per-shot readout sequencer for the demodulation datapath.
- On a selected trigger line it waits a programmable delay, then opens an integration window for a programmed number of valid FCx5 beats (5 samples per beat), then pulses a result trigger.
- Configured and monitored over the HVI register port.
- Sits between trigger_in/HVI and the demodulator's window-enable inputs.

Parameters:
- CNT_W, 16, width of the DELAY and LENGTH counters.
- SHOT_W, 8, width of the REPEAT register and shot counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- HVI_sdi_mem_S_address  in  10  register address.
- HVI_sdi_mem_S_wrEn  in  1  write strobe.
- HVI_sdi_mem_S_rdEn  in  1  read strobe.
- HVI_sdi_mem_S_wrData  in  32  write data.
- HVI_sdi_mem_M_rdData  out  32  read data, registered.
- trigger_in  in  5  external trigger lines.
- in_valid  in  1  FCx5 stream valid; one beat per cycle when high.
- win_en  out  1  integration window active.
- win_start  out  1  pulse on the first window beat.
- win_last  out  1  pulse on the final window beat.
- result_trig  out  1  one-cycle pulse after the window closes.
- busy  out  1  high in DELAY or INTEG.

Behaviour:
- Reset: all outputs 0, registers 0, state IDLE.
- Register map (address, access, contents):
  - 0 CTRL (RW): bit0 enable; bits[3:1] trig_sel (values 5-7 select no trigger).
  - 1 DELAY (RW): [CNT_W-1:0].
  - 2 LENGTH (RW): [CNT_W-1:0]; 0 is treated as 1.
  - 3 REPEAT (RW): [SHOT_W-1:0]; 0 means free-run.
  - 4 STATUS (RO except bit31): [2:0] state; [15:8] shot_count; bit31 overrun, sticky, cleared by writing 1 to address 4.
  - Unmapped addresses read 0.
- Read timing: rdData is valid the cycle after rdEn and holds until the next read.
- Edge detect: trigger_in is registered. An edge exists in cycle t when trigger_in[trig_sel] is 1 at t and was 0 at t-1.
- FSM states and encodings: IDLE=0, WAIT=1, DELAY=2, INTEG=3, DONE=4.
- IDLE -> WAIT: when enable=1. shot_count is cleared on this transition.
- WAIT -> DELAY: on an edge. DELAY, LENGTH and REPEAT are latched into shadow registers on that edge. If shadow DELAY=0, go straight to INTEG instead.
- DELAY:
  - Counts clock cycles regardless of in_valid.
  - Exits to INTEG after exactly DELAY cycles.
  - win_en first rises at cycle t+1+DELAY.
- INTEG:
  - win_en=1.
  - Counts only cycles with in_valid=1.
  - win_start=1 on the first counted beat. win_last=1 on beat LENGTH, then go to DONE.
  - When LENGTH=1, win_start and win_last fire together.
- DONE:
  - Lasts one cycle; result_trig=1; shot_count increments (saturating).
  - If REPEAT≠0 and shot_count+1==REPEAT: go to IDLE and auto-clear CTRL.enable.
  - Otherwise return to WAIT.
- An edge in DELAY, INTEG or DONE is ignored and sets overrun.
- Register writes mid-shot affect only the next shot, because the shadow registers are in use.
- Writing enable=0 mid-shot:
  - Abort to IDLE on the next cycle.
  - win_en drops the same cycle the state leaves INTEG.
  - No result_trig or win_last; shot_count is retained.
- Simultaneous edge and enable 0->1: the edge is ignored, because the FSM is still in IDLE.
- Asserting rst at any time returns everything to the reset values immediately.

Optional Feature:
- Macro: DEMOD_SEQ_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter (wraps) is latched on each accepted edge.
  - The latched value is readable at address 5.
  - The counter is cleared only by rst.
- Undefined: no counter; address 5 reads 0.

Test Plan:
- DELAY=3, LENGTH=4, REPEAT=1, trig_sel=0, enable, in_valid=1, pulse trigger_in[0] at cycle t:
  - win_en high for cycles t+4..t+7.
  - win_start at t+4; win_last at t+7; result_trig at t+8.
  - STATUS reads state=0, shot_count=1; CTRL.enable reads 0.
- As above, but in_valid low on alternate cycles: win_en spans 7 cycles; win_last on the 4th valid beat.
- DELAY=0, LENGTH=0: win_en rises at t+1 for exactly 1 cycle with win_start=win_last=1; result_trig at t+2.
- REPEAT=0, DELAY=2, LENGTH=2, second trigger arrives during INTEG:
  - Overrun reads 1 and shot_count stays at 1.
  - Writing 1 to STATUS bit31 clears overrun.
  - A later trigger produces shot 2.
- Write enable=0 during INTEG: state is IDLE on the next cycle, win_en=0, no result_trig, busy=0.
- With DEMOD_SEQ_TIMESTAMP_EN defined:
  - Release rst at cycle 0, trigger edge at cycle 100: address 5 reads 100.
  - Without the macro, address 5 reads 0.

Source files
------------

// File: rtl/demod_window_sequencer.sv
// Per-shot demodulation window sequencer: trigger -> delay -> integration window -> result pulse.
// Optional DEMOD_SEQ_TIMESTAMP_EN adds a free-running cycle counter latched on each accepted edge.
module demod_window_sequencer #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned SHOT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  HVI_sdi_mem_S_address,
   input  logic        HVI_sdi_mem_S_wrEn,
   input  logic        HVI_sdi_mem_S_rdEn,
   input  logic [31:0] HVI_sdi_mem_S_wrData,
   output logic [31:0] HVI_sdi_mem_M_rdData,
   input  logic [4:0]  trigger_in,
   input  logic        in_valid,
   output logic        win_en,
   output logic        win_start,
   output logic        win_last,
   output logic        result_trig,
   output logic        busy
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StWait  = 3'd1;
   localparam logic [2:0] StDelay = 3'd2;
   localparam logic [2:0] StInteg = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   localparam logic [CNT_W-1:0]  CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [SHOT_W:0]   ShotOne = {{SHOT_W{1'b0}}, 1'b1};

   logic              ctrl_en_q, ctrl_en_d;
   logic [2:0]        trig_sel_q, trig_sel_d;
   logic [CNT_W-1:0]  delay_q, delay_d;
   logic [CNT_W-1:0]  length_q, length_d;
   logic [SHOT_W-1:0] repeat_q, repeat_d;
   logic              overrun_q, overrun_d;
   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  sh_delay_q, sh_delay_d;
   logic [CNT_W-1:0]  sh_len_q, sh_len_d;
   logic [SHOT_W-1:0] sh_rep_q, sh_rep_d;
   logic [SHOT_W-1:0] shot_q, shot_d;
   logic [4:0]        trig_q;
   logic [31:0]       rdata_q, rdata_d;

   logic              wr_ctrl;
   logic              en_eff;
   logic [4:0]        rise;
   logic              edge_det;
   logic              accept;
   logic              clr_en;
   logic [CNT_W-1:0]  len_last;
   logic [31:0]       rd_mux;
   logic              unused_wrdata;

   assign unused_wrdata = ^HVI_sdi_mem_S_wrData;

   // A write to CTRL acts in its own cycle so an enable=0 write aborts on the next cycle.
   assign wr_ctrl = HVI_sdi_mem_S_wrEn && (HVI_sdi_mem_S_address == 10'd0);
   assign en_eff  = wr_ctrl ? HVI_sdi_mem_S_wrData[0] : ctrl_en_q;

   assign rise = trigger_in & ~trig_q;

   always_comb begin
      edge_det = 1'b0;
      case (trig_sel_q)
         3'd0:    edge_det = rise[0];
         3'd1:    edge_det = rise[1];
         3'd2:    edge_det = rise[2];
         3'd3:    edge_det = rise[3];
         3'd4:    edge_det = rise[4];
         default: edge_det = 1'b0;
      endcase
   end

   assign len_last = ((sh_len_q == '0) ? CntOne : sh_len_q) - CntOne;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_delay_d = sh_delay_q;
      sh_len_d   = sh_len_q;
      sh_rep_d   = sh_rep_q;
      shot_d     = shot_q;
      accept     = 1'b0;
      clr_en     = 1'b0;
      win_start  = 1'b0;
      win_last   = 1'b0;
      case (state_q)
         StIdle: begin
            if (en_eff) begin
               state_d = StWait;
               shot_d  = '0;
            end
         end
         StWait: begin
            if (!en_eff) begin
               state_d = StIdle;
            end else if (edge_det) begin
               accept     = 1'b1;
               sh_delay_d = delay_q;
               sh_len_d   = length_q;
               sh_rep_d   = repeat_q;
               cnt_d      = '0;
               state_d    = (delay_q == '0) ? StInteg : StDelay;
            end
         end
         StDelay: begin
            if (!en_eff) begin
               state_d = StIdle;
            end else if (cnt_q == sh_delay_q - CntOne) begin
               cnt_d   = '0;
               state_d = StInteg;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StInteg: begin
            if (!en_eff) begin
               state_d = StIdle;
            end else if (in_valid) begin
               win_start = (cnt_q == '0);
               if (cnt_q == len_last) begin
                  win_last = 1'b1;
                  state_d  = StDone;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
         end
         StDone: begin
            if (shot_q != '1) begin
               shot_d = shot_q + ShotOne[SHOT_W-1:0];
            end
            if (!en_eff) begin
               state_d = StIdle;
            end else if ((sh_rep_q != '0) && (({1'b0, shot_q} + ShotOne) == {1'b0, sh_rep_q})) begin
               state_d = StIdle;
               clr_en  = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ctrl_en_d  = ctrl_en_q;
      trig_sel_d = trig_sel_q;
      delay_d    = delay_q;
      length_d   = length_q;
      repeat_d   = repeat_q;
      overrun_d  = overrun_q;
      if (HVI_sdi_mem_S_wrEn) begin
         case (HVI_sdi_mem_S_address)
            10'd0: begin
               ctrl_en_d  = HVI_sdi_mem_S_wrData[0];
               trig_sel_d = HVI_sdi_mem_S_wrData[3:1];
            end
            10'd1: delay_d  = HVI_sdi_mem_S_wrData[CNT_W-1:0];
            10'd2: length_d = HVI_sdi_mem_S_wrData[CNT_W-1:0];
            10'd3: repeat_d = HVI_sdi_mem_S_wrData[SHOT_W-1:0];
            10'd4: if (HVI_sdi_mem_S_wrData[31]) overrun_d = 1'b0;
            default: ;
         endcase
      end
      if (clr_en) begin
         ctrl_en_d = 1'b0;
      end
      // A new overrun event wins over a simultaneous clear.
      if (edge_det && ((state_q == StDelay) || (state_q == StInteg) || (state_q == StDone))) begin
         overrun_d = 1'b1;
      end
   end

`ifdef DEMOD_SEQ_TIMESTAMP_EN
   logic [31:0] ts_cnt_q;
   logic [31:0] ts_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_cnt_q <= '0;
         ts_q     <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 32'd1;
         if (accept) begin
            ts_q <= ts_cnt_q;
         end
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

   always_comb begin
      rd_mux = '0;
      case (HVI_sdi_mem_S_address)
         10'd0: rd_mux[3:0] = {trig_sel_q, ctrl_en_q};
         10'd1: rd_mux[CNT_W-1:0] = delay_q;
         10'd2: rd_mux[CNT_W-1:0] = length_q;
         10'd3: rd_mux[SHOT_W-1:0] = repeat_q;
         10'd4: begin
            rd_mux[2:0]         = state_q;
            rd_mux[8 +: SHOT_W] = shot_q;
            rd_mux[31]          = overrun_q;
         end
`ifdef DEMOD_SEQ_TIMESTAMP_EN
         10'd5: rd_mux = ts_q;
`endif
         default: rd_mux = '0;
      endcase
   end

   assign rdata_d = HVI_sdi_mem_S_rdEn ? rd_mux : rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_en_q  <= 1'b0;
         trig_sel_q <= '0;
         delay_q    <= '0;
         length_q   <= '0;
         repeat_q   <= '0;
         overrun_q  <= 1'b0;
         state_q    <= StIdle;
         cnt_q      <= '0;
         sh_delay_q <= '0;
         sh_len_q   <= '0;
         sh_rep_q   <= '0;
         shot_q     <= '0;
         trig_q     <= '0;
         rdata_q    <= '0;
      end else begin
         ctrl_en_q  <= ctrl_en_d;
         trig_sel_q <= trig_sel_d;
         delay_q    <= delay_d;
         length_q   <= length_d;
         repeat_q   <= repeat_d;
         overrun_q  <= overrun_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_delay_q <= sh_delay_d;
         sh_len_q   <= sh_len_d;
         sh_rep_q   <= sh_rep_d;
         shot_q     <= shot_d;
         trig_q     <= trigger_in;
         rdata_q    <= rdata_d;
      end
   end

   assign HVI_sdi_mem_M_rdData = rdata_q;
   assign win_en      = (state_q == StInteg);
   assign result_trig = (state_q == StDone);
   assign busy        = (state_q == StDelay) || (state_q == StInteg);

endmodule

// File: tb/tb_demod_window_sequencer.sv
// Directed bench for demod_window_sequencer; traces are packed per cycle, bit k = cycle t+k.
module tb_demod_window_sequencer;

   logic        clk;
   logic        rst;
   logic [9:0]  addr;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [4:0]  trigger_in;
   logic        in_valid;
   logic        win_en;
   logic        win_start;
   logic        win_last;
   logic        result_trig;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   demod_window_sequencer #(
      .CNT_W  (16),
      .SHOT_W (8)
   ) u_dut (
      .clk                   (clk),
      .rst                   (rst),
      .HVI_sdi_mem_S_address (addr),
      .HVI_sdi_mem_S_wrEn    (wr_en),
      .HVI_sdi_mem_S_rdEn    (rd_en),
      .HVI_sdi_mem_S_wrData  (wr_data),
      .HVI_sdi_mem_M_rdData  (rd_data),
      .trigger_in            (trigger_in),
      .in_valid              (in_valid),
      .win_en                (win_en),
      .win_start             (win_start),
      .win_last              (win_last),
      .result_trig           (result_trig),
      .busy                  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // All tasks start and end just after a falling clock edge.
   task automatic reg_wr(input logic [9:0] a, input logic [31:0] d);
      addr = a; wr_data = d; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic reg_rd(input logic [9:0] a, output logic [31:0] d);
      addr = a; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      d = rd_data;
   endtask

   task automatic rd_check(input string tag, input logic [9:0] a, input logic [31:0] exp);
      logic [31:0] d;
      reg_rd(a, d);
      check_eq(tag, d, exp);
   endtask

   task automatic run_seq(input int ncyc, input logic [15:0] trig_pat, input logic [15:0] val_pat,
                          input logic [4:0] mask, input int abort_at,
                          output logic [15:0] en_tr, output logic [15:0] st_tr,
                          output logic [15:0] ls_tr, output logic [15:0] rt_tr,
                          output logic [15:0] bz_tr);
      en_tr = '0; st_tr = '0; ls_tr = '0; rt_tr = '0; bz_tr = '0;
      for (int k = 0; k < ncyc; k++) begin
         trigger_in = trig_pat[k] ? mask : 5'd0;
         in_valid   = val_pat[k];
         if (k == abort_at) begin
            addr = 10'd0; wr_data = 32'd0; wr_en = 1'b1;
         end else begin
            wr_en = 1'b0;
         end
         #1;
         en_tr[k] = win_en;
         st_tr[k] = win_start;
         ls_tr[k] = win_last;
         rt_tr[k] = result_trig;
         bz_tr[k] = busy;
         @(negedge clk);
      end
      trigger_in = '0; in_valid = 1'b0; wr_en = 1'b0;
   endtask

   task automatic shot_check(input string tag, input int ncyc, input logic [15:0] trig_pat,
                             input logic [15:0] val_pat, input logic [4:0] mask,
                             input int abort_at, input logic [15:0] x_en,
                             input logic [15:0] x_st, input logic [15:0] x_ls,
                             input logic [15:0] x_rt, input logic [15:0] x_bz);
      logic [15:0] en_tr, st_tr, ls_tr, rt_tr, bz_tr;
      run_seq(ncyc, trig_pat, val_pat, mask, abort_at, en_tr, st_tr, ls_tr, rt_tr, bz_tr);
      check_eq({tag, ".win_en"}, {16'd0, en_tr}, {16'd0, x_en});
      check_eq({tag, ".win_start"}, {16'd0, st_tr}, {16'd0, x_st});
      check_eq({tag, ".win_last"}, {16'd0, ls_tr}, {16'd0, x_ls});
      check_eq({tag, ".result_trig"}, {16'd0, rt_tr}, {16'd0, x_rt});
      check_eq({tag, ".busy"}, {16'd0, bz_tr}, {16'd0, x_bz});
   endtask

   initial begin
      rst = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      trigger_in = '0; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset.outputs", {26'd0, win_en, win_start, win_last, result_trig, busy, 1'b0}, 32'd0);
      check_eq("reset.rddata", rd_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      rd_check("reset.ctrl", 10'd0, 32'd0);
      rd_check("reset.status", 10'd4, 32'd0);
      rd_check("unmapped.read", 10'd9, 32'd0);

      // Single shot: DELAY=3 LENGTH=4 REPEAT=1, continuous valid
      reg_wr(10'd1, 32'd3);
      reg_wr(10'd2, 32'd4);
      reg_wr(10'd3, 32'd1);
      reg_wr(10'd0, 32'd1);
      rd_check("t1.status_wait", 10'd4, 32'h0000_0001);
      rd_check("t1.length_rb", 10'd2, 32'd4);
      shot_check("t1", 12, 16'h0001, 16'hFFFF, 5'b00001, -1,
                 16'h00F0, 16'h0010, 16'h0080, 16'h0100, 16'h00FE);
      rd_check("t1.status_end", 10'd4, 32'h0000_0100);
      rd_check("t1.ctrl_autoclr", 10'd0, 32'd0);

      // Same shot with valid on alternate cycles
      reg_wr(10'd0, 32'd1);
      shot_check("t2", 14, 16'h0001, 16'h5555, 5'b00001, -1,
                 16'h07F0, 16'h0010, 16'h0400, 16'h0800, 16'h07FE);
      rd_check("t2.status_end", 10'd4, 32'h0000_0100);

      // DELAY=0, LENGTH=0 (treated as 1)
      reg_wr(10'd1, 32'd0);
      reg_wr(10'd2, 32'd0);
      reg_wr(10'd0, 32'd1);
      shot_check("t3", 6, 16'h0001, 16'hFFFF, 5'b00001, -1,
                 16'h0002, 16'h0002, 16'h0002, 16'h0004, 16'h0002);

      // trig_sel=5 selects no trigger line
      reg_wr(10'd3, 32'd0);
      reg_wr(10'd0, 32'h0000_000B);
      shot_check("sel5", 6, 16'h0001, 16'hFFFF, 5'b11111, -1,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      rd_check("sel5.status", 10'd4, 32'h0000_0001);

      // Free-run on line 2 with a second trigger during INTEG
      reg_wr(10'd1, 32'd2);
      reg_wr(10'd2, 32'd2);
      reg_wr(10'd0, 32'h0000_0005);
      shot_check("t4a", 8, 16'h0009, 16'hFFFF, 5'b00100, -1,
                 16'h0018, 16'h0008, 16'h0010, 16'h0020, 16'h001E);
      rd_check("t4.status_overrun", 10'd4, 32'h8000_0101);
      reg_wr(10'd4, 32'h8000_0000);
      rd_check("t4.status_cleared", 10'd4, 32'h0000_0101);
      shot_check("t4b", 8, 16'h0001, 16'hFFFF, 5'b00100, -1,
                 16'h0018, 16'h0008, 16'h0010, 16'h0020, 16'h001E);
      rd_check("t4.status_shot2", 10'd4, 32'h0000_0201);

      // Abort by writing enable=0 during INTEG
      reg_wr(10'd1, 32'd1);
      reg_wr(10'd2, 32'd8);
      shot_check("t5", 10, 16'h0001, 16'hFFFF, 5'b00100, 4,
                 16'h001C, 16'h0004, 16'h0000, 16'h0000, 16'h001E);
      rd_check("t5.status", 10'd4, 32'h0000_0200);
      rd_check("t5.ctrl", 10'd0, 32'd0);

      // Asynchronous reset mid-shot
      reg_wr(10'd1, 32'd5);
      reg_wr(10'd0, 32'd1);
      rd_check("t6.status_pre", 10'd4, 32'h0000_0001);
      trigger_in = 5'b00001;
      @(negedge clk);
      trigger_in = '0;
      @(negedge clk);
      #1;
      check_eq("t6.busy_pre", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      check_eq("t6.busy_rst", {31'd0, busy}, 32'd0);
      check_eq("t6.rddata_rst", rd_data, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Timestamp: release at cycle 0, edge at cycle 100
      rd_check("t7.delay_rst", 10'd1, 32'd0);
      rd_check("t7.status_rst", 10'd4, 32'd0);
      reg_wr(10'd0, 32'd1);
      repeat (97) @(negedge clk);
      trigger_in = 5'b00001;
      @(negedge clk);
      trigger_in = '0;
`ifdef DEMOD_SEQ_TIMESTAMP_EN
      rd_check("t7.timestamp", 10'd5, 32'd100);
`else
      rd_check("t7.timestamp", 10'd5, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
